// File: rtl/uart_tx_fifo.sv
// UART transmitter with a valid/ready input FIFO, runtime baud divisor,
// 5..9 data bits, optional even/odd parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST = 4'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;

  state_t            state, state_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [DIV_W-1:0]  div_q, div_n, cnt, cnt_n;
  logic [3:0]        bitcnt, bit_n;
  logic              par_q, par_n, pen_q, pen_n, s2_q, s2_n, tx_n;
  logic              bit_end, start_frame;

  assign in_ready = (fifo_cnt != FULL);
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || (fifo_cnt != '0);
  assign bit_end  = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // tx_n is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_n     = state;
    data_n      = data_q;
    div_n       = div_q;
    par_n       = par_q;
    pen_n       = pen_q;
    s2_n        = s2_q;
    bit_n       = bitcnt;
    tx_n        = tx;
    pop         = 1'b0;
    tx_done     = 1'b0;
    start_frame = 1'b0;
    cnt_n       = cnt - 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fifo_cnt != '0) start_frame = 1'b1;
      end
      START: if (bit_end) begin
        state_n = DATA;
        cnt_n   = div_q;
        bit_n   = '0;
        tx_n    = data_q[0];
      end
      DATA: if (bit_end) begin
        cnt_n = div_q;
        if (bitcnt == LAST) begin
          bit_n = '0;
          if (pen_q) begin
            state_n = PARITY;
            tx_n    = par_q;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n  = bitcnt + 1'b1;
          data_n = data_q >> 1;
          tx_n   = data_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        cnt_n   = div_q;
        bit_n   = '0;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (s2_q && bitcnt == '0) begin
          bit_n = 4'd1;
          cnt_n = div_q;
        end else begin
          tx_done = 1'b1;
          if (fifo_cnt != '0) start_frame = 1'b1;
          else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Frame start also serves back-to-back frames straight out of STOP.
    if (start_frame) begin
      pop     = 1'b1;
      state_n = START;
      data_n  = mem[rd_ptr];
      par_n   = (^mem[rd_ptr]) ^ parity_mode[1];
      pen_n   = ^parity_mode;
      s2_n    = stop2;
      div_n   = baud_div;
      cnt_n   = baud_div;
      tx_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      div_q  <= '0;
      cnt    <= '0;
      bitcnt <= '0;
      par_q  <= 1'b0;
      pen_q  <= 1'b0;
      s2_q   <= 1'b0;
      tx     <= 1'b1;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      div_q  <= div_n;
      cnt    <= cnt_n;
      bitcnt <= bit_n;
      par_q  <= par_n;
      pen_q  <= pen_n;
      s2_q   <= s2_n;
      tx     <= tx_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table of single frames plus
// burst, mid-frame reconfiguration and mid-frame reset sequences.
module tb_uart_tx_fifo;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] baud_div, baud_div5;
  logic [1:0]  parity_mode, parity_mode5;
  logic        stop2, stop25;
  logic [7:0]  in_data;
  logic [4:0]  in_data5;
  logic        in_valid, in_valid5;
  logic        in_ready, tx, busy, tx_done;
  logic        in_ready5, tx5, busy5, tx_done5;
  logic [2:0]  fifo_cnt, fifo_cnt5;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_cnt(fifo_cnt));

  uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div5), .parity_mode(parity_mode5),
    .stop2(stop25), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .tx(tx5), .busy(busy5), .tx_done(tx_done5), .fifo_cnt(fifo_cnt5));

  int checks = 0, errors = 0;

  typedef struct {
    bit          w5;
    logic [8:0]  data;
    logic [1:0]  pm;
    logic        s2;
    int          dv;
    logic [11:0] eb;   // bit i = level of the i-th transmitted bit
    int          nb;
    string       nm;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_word(input bit w5, input logic [8:0] d, input logic [1:0] pm,
                           input logic s2, input int dv);
    @(negedge clk);
    if (w5) begin
      baud_div5 = 16'(dv); parity_mode5 = pm; stop25 = s2; in_data5 = d[4:0]; in_valid5 = 1'b1;
    end else begin
      baud_div = 16'(dv); parity_mode = pm; stop2 = s2; in_data = d[7:0]; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid5 = 1'b0;
  endtask

  task automatic check_frame(input bit w5, input logic [11:0] eb, input int nb,
                             input int dv, input string nm);
    int total, ms, md;
    logic t, d;
    total = nb * (dv + 1);
    ms = 0; md = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      t = w5 ? tx5 : tx;
      d = w5 ? tx_done5 : tx_done;
      if (t !== eb[c / (dv + 1)]) ms++;
      if (d !== (c == total - 1)) md++;
    end
    chk({nm, "_bits"}, ms, 0);
    chk({nm, "_done"}, md, 0);
  endtask

  task automatic check_idle(input bit w5, input string nm);
    @(negedge clk);
    chk({nm, "_busy_off"}, int'(w5 ? busy5 : busy), 0);
    chk({nm, "_tx_idle"},  int'(w5 ? tx5 : tx), 1);
  endtask

  function automatic logic burst_bit(input int c);
    int b, w;
    b = (c % 20) / 2;
    w = c / 20 + 1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return 1'((w >> (b - 1)) & 1);
  endfunction

  int   pw, pguard, mg, mms, mmd, bad;
  logic prdy, saw_full;

  initial begin
    baud_div = '0; parity_mode = '0; stop2 = 1'b0; in_data = '0; in_valid = 1'b0;
    baud_div5 = '0; parity_mode5 = '0; stop25 = 1'b0; in_data5 = '0; in_valid5 = 1'b0;

    vecs[0] = '{0, 9'h55, 2'b00, 1'b0, 3, 12'h2AA, 10, "v55_none"};
    vecs[1] = '{0, 9'h55, 2'b01, 1'b0, 3, 12'h4AA, 11, "v55_even"};
    vecs[2] = '{0, 9'h55, 2'b10, 1'b0, 3, 12'h6AA, 11, "v55_odd"};
    vecs[3] = '{0, 9'h55, 2'b01, 1'b1, 3, 12'hCAA, 12, "v55_even_s2"};
    vecs[4] = '{0, 9'hA3, 2'b11, 1'b0, 0, 12'h346, 10, "vA3_div0"};
    vecs[5] = '{0, 9'h80, 2'b10, 1'b0, 2, 12'h500, 11, "v80_odd"};
    vecs[6] = '{1, 9'h1F, 2'b10, 1'b0, 0, 12'h0BE, 8,  "w5_1F_odd"};

    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_cnt", int'(fifo_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      push_word(vecs[i].w5, vecs[i].data, vecs[i].pm, vecs[i].s2, vecs[i].dv);
      chk({vecs[i].nm, "_pre"}, int'(vecs[i].w5 ? tx5 : tx), 1);
      check_frame(vecs[i].w5, vecs[i].eb, vecs[i].nb, vecs[i].dv, vecs[i].nm);
      check_idle(vecs[i].w5, vecs[i].nm);
    end

    // Six words held on in_valid: FIFO fills, then frames stream with no gap.
    baud_div = 16'd1; parity_mode = 2'b00; stop2 = 1'b0;
    saw_full = 1'b0;
    fork
      begin
        pw = 1; pguard = 0;
        @(negedge clk);
        in_data = 8'd1; in_valid = 1'b1;
        while (pw <= 6 && pguard < 400) begin
          prdy = in_ready;
          if (fifo_cnt == 3'd4 && !in_ready) saw_full = 1'b1;
          @(negedge clk);
          pguard++;
          if (prdy) begin
            pw++;
            if (pw <= 6) in_data = 8'(pw);
          end
        end
        in_valid = 1'b0;
        chk("burst_accept", pw, 7);
      end
      begin
        mg = 0; mms = 0; mmd = 0;
        while (tx !== 1'b0 && mg < 50) begin
          @(negedge clk);
          mg++;
        end
        chk("burst_start", int'(mg < 50), 1);
        for (int c = 0; c < 120; c++) begin
          if (c > 0) @(negedge clk);
          if (tx !== burst_bit(c)) mms++;
          if (tx_done !== ((c % 20) == 19)) mmd++;
        end
        chk("burst_bits", mms, 0);
        chk("burst_done", mmd, 0);
      end
    join
    chk("burst_full_seen", int'(saw_full), 1);
    check_idle(0, "burst");

    // Config changes mid-frame apply only to the next frame.
    push_word(0, 9'h55, 2'b00, 1'b0, 3);
    fork
      begin
        check_frame(0, 12'h2AA, 10, 3, "mid_f1");
        check_frame(0, 12'h4AA, 11, 7, "mid_f2");
      end
      begin
        repeat (10) @(negedge clk);
        baud_div = 16'd7; parity_mode = 2'b01; in_data = 8'h55; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check_idle(0, "mid");

    // Reset in the middle of DATA with two words queued.
    baud_div = 16'd3; parity_mode = 2'b00;
    @(negedge clk); in_data = 8'h01; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h02;
    @(negedge clk); in_data = 8'h03;
    @(negedge clk); in_valid = 1'b0;
    chk("rst_queued", int'(fifo_cnt), 2);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", int'(tx), 1);
    chk("arst_cnt", int'(fifo_cnt), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    push_word(0, 9'h55, 2'b00, 1'b0, 3);
    check_frame(0, 12'h2AA, 10, 3, "post_rst");
    check_idle(0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
